// File: rtl/alarm_ctrl_pkg.sv
// Shared types and constants for the alarm-clock button sequencer.
// Holds the FSM encoding, display mode codes, BCD digit limits and the digit-edit helper.
package alarm_ctrl_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [3:0] {
    ST_RUN,
    ST_EDIT_TIME,
    ST_EDIT_ALARM,
    ST_COMMIT_TIME,
    ST_COMMIT_ALARM,
    ST_SNOOZE_STOP,
    ST_SNOOZE_LOAD,
    ST_DISMISS_STOP,
    ST_RESTORE_LOAD
  } state_e;

  localparam logic [1:0] MODE_RUN       = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;

  localparam logic [1:0]       HOUR1_MAX     = 2'd2;
  localparam logic [BCD_W-1:0] HOUR0_MAX     = 4'd9;
  localparam logic [BCD_W-1:0] HOUR0_MAX_H20 = 4'd3;
  localparam logic [BCD_W-1:0] MIN1_MAX      = 4'd5;
  localparam logic [BCD_W-1:0] MIN0_MAX      = 4'd9;

  typedef struct packed {
    logic [1:0]       h1;
    logic [BCD_W-1:0] h0;
    logic [BCD_W-1:0] m1;
    logic [BCD_W-1:0] m0;
  } hhmm_t;

  // Increment one digit with wrap; raising hour tens to 2 pulls hour units into 0..3.
  function automatic hhmm_t bump_digit(input hhmm_t t, input logic [1:0] dig);
    hhmm_t r;
    r = t;
    case (dig)
      2'd0: begin
        r.h1 = (t.h1 >= HOUR1_MAX) ? 2'd0 : t.h1 + 2'd1;
        if (r.h1 == HOUR1_MAX && t.h0 > HOUR0_MAX_H20) r.h0 = HOUR0_MAX_H20;
      end
      2'd1: r.h0 = (t.h0 >= ((t.h1 == HOUR1_MAX) ? HOUR0_MAX_H20 : HOUR0_MAX)) ? '0 : t.h0 + 4'd1;
      2'd2: r.m1 = (t.m1 >= MIN1_MAX) ? '0 : t.m1 + 4'd1;
      default: r.m0 = (t.m0 >= MIN0_MAX) ? '0 : t.m0 + 4'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/time_add_minutes.sv
// Combinational HH:MM BCD plus 0..9 minutes, with minute carry into the hour and 24-h wrap.
module time_add_minutes
  import alarm_ctrl_pkg::*;
(
  input  hhmm_t            t_i,
  input  logic [BCD_W-1:0] add_i,
  output hhmm_t            sum_o
);

  logic [BCD_W:0]   m0_sum;
  logic [BCD_W:0]   m0_adj;
  logic [BCD_W-1:0] h0_inc;
  logic             min_carry;
  logic             hr_carry;

  always_comb begin
    sum_o     = t_i;
    m0_sum    = {1'b0, t_i.m0} + {1'b0, add_i};
    min_carry = (m0_sum > {1'b0, MIN0_MAX});
    m0_adj    = min_carry ? m0_sum - ({1'b0, MIN0_MAX} + 1'b1) : m0_sum;
    sum_o.m0  = m0_adj[BCD_W-1:0];
    hr_carry  = 1'b0;
    h0_inc    = t_i.h0 + 4'd1;
    if (min_carry) begin
      if (t_i.m1 >= MIN1_MAX) begin
        sum_o.m1 = '0;
        hr_carry = 1'b1;
      end else begin
        sum_o.m1 = t_i.m1 + 4'd1;
      end
    end
    if (hr_carry) begin
      if (t_i.h1 == HOUR1_MAX && h0_inc > HOUR0_MAX_H20) begin
        sum_o.h1 = '0;
        sum_o.h0 = '0;
      end else if (h0_inc > HOUR0_MAX) begin
        sum_o.h0 = '0;
        sum_o.h1 = t_i.h1 + 2'd1;
      end else begin
        sum_o.h0 = h0_inc;
      end
    end
  end

endmodule

// File: rtl/alarm_mode_controller.sv
// Button sequencer in front of alarm_clock: digit editing, edit timeout, snooze and restore.
// Every load/stop command is held until a tick_1s so the 1-s-clocked alarm_clock samples it.
module alarm_mode_controller
  import alarm_ctrl_pkg::*;
#(
  parameter int SNOOZE_MIN   = 5,
  parameter int EDIT_TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_next,
  input  logic       btn_snooze,
  input  logic       alarm_active,
  input  logic [1:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] minute_in1,
  output logic [3:0] minute_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       stop_alarm,
  output logic       alarm_on,
  output logic [1:0] mode,
  output logic [1:0] edit_digit,
  output logic       snooze_active
);

  localparam logic [BCD_W-1:0] SNOOZE_BCD = SNOOZE_MIN[BCD_W-1:0];
  localparam logic [5:0]       TMO_LAST   = EDIT_TIMEOUT[5:0] - 6'd1;

  state_e     state_q, state_d;
  logic [3:0] btn_q, btn_now, edges;
  logic       ev_mode, ev_next, ev_up;
  hhmm_t      cur, snooze_sum;
  hhmm_t      edit_q, edit_d, shadow_q, shadow_d, bus_q, bus_d;
  logic [1:0] digit_q, digit_d, mode_q, mode_d;
  logic [5:0] tmo_q, tmo_d;
  logic       load_time_q, load_time_d, load_alarm_q, load_alarm_d;
  logic       stop_q, stop_d, alarm_on_q, alarm_on_d, snooze_q, snooze_d;

  // Bit order {snooze, mode, next, up} doubles as the edge priority order.
  assign btn_now = {btn_snooze, btn_mode, btn_next, btn_up};
  assign edges   = btn_now & ~btn_q;
  assign ev_mode = edges[2] & ~edges[3];
  assign ev_next = edges[1] & ~|edges[3:2];
  assign ev_up   = edges[0] & ~|edges[3:1];
  assign cur     = {cur_hour1, cur_hour0, cur_min1, cur_min0};

  time_add_minutes u_snooze_add (
    .t_i   (cur),
    .add_i (SNOOZE_BCD),
    .sum_o (snooze_sum)
  );

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    digit_d    = digit_q;
    shadow_d   = shadow_q;
    bus_d      = bus_q;
    tmo_d      = '0;
    alarm_on_d = alarm_on_q;
    snooze_d   = snooze_q;
    case (state_q)
      ST_RUN: begin
        if (alarm_active) begin
          if (edges[3])     state_d = ST_SNOOZE_STOP;
          else if (ev_mode) state_d = ST_DISMISS_STOP;
        end else if (ev_mode) begin
          state_d = ST_EDIT_TIME;
          edit_d  = cur;
          digit_d = 2'd0;
        end else if (ev_up) begin
          alarm_on_d = ~alarm_on_q;
        end
      end
      ST_EDIT_TIME, ST_EDIT_ALARM: begin
        if (|edges) begin
          tmo_d = '0;
        end else if (tick_1s) begin
          if (tmo_q == TMO_LAST) state_d = ST_RUN;
          else                   tmo_d = tmo_q + 6'd1;
        end else begin
          tmo_d = tmo_q;
        end
        if (ev_mode) begin
          if (state_q == ST_EDIT_TIME) begin
            state_d = ST_EDIT_ALARM;
            edit_d  = shadow_q;
            digit_d = 2'd0;
          end else begin
            state_d = ST_RUN;
          end
        end else if (ev_next) begin
          if (digit_q == 2'd3)
            state_d = (state_q == ST_EDIT_TIME) ? ST_COMMIT_TIME : ST_COMMIT_ALARM;
          else
            digit_d = digit_q + 2'd1;
        end else if (ev_up) begin
          edit_d = bump_digit(edit_q, digit_q);
        end
      end
      ST_COMMIT_TIME, ST_COMMIT_ALARM: if (tick_1s) state_d = ST_RUN;
      ST_SNOOZE_STOP:  if (tick_1s) state_d = ST_SNOOZE_LOAD;
      ST_SNOOZE_LOAD: begin
        if (tick_1s) begin
          state_d  = ST_RUN;
          snooze_d = 1'b1;
        end
      end
      ST_DISMISS_STOP: if (tick_1s) state_d = snooze_q ? ST_RESTORE_LOAD : ST_RUN;
      ST_RESTORE_LOAD: begin
        if (tick_1s) begin
          state_d  = ST_RUN;
          snooze_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Buses are captured once on entry so they stay put while cur_* advances.
    if (state_d != state_q) begin
      case (state_d)
        ST_COMMIT_TIME, ST_COMMIT_ALARM: bus_d = edit_q;
        ST_SNOOZE_LOAD:                  bus_d = snooze_sum;
        ST_RESTORE_LOAD:                 bus_d = shadow_q;
        default: ;
      endcase
    end
    if (state_d == ST_COMMIT_ALARM) shadow_d = edit_q;

    load_time_d  = (state_d == ST_COMMIT_TIME);
    load_alarm_d = state_d inside {ST_COMMIT_ALARM, ST_SNOOZE_LOAD, ST_RESTORE_LOAD};
    stop_d       = state_d inside {ST_SNOOZE_STOP, ST_DISMISS_STOP};
    case (state_d)
      ST_EDIT_TIME:  mode_d = MODE_SET_TIME;
      ST_EDIT_ALARM: mode_d = MODE_SET_ALARM;
      default:       mode_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      btn_q        <= '1;
      edit_q       <= '0;
      digit_q      <= '0;
      shadow_q     <= '0;
      bus_q        <= '0;
      tmo_q        <= '0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      stop_q       <= 1'b0;
      alarm_on_q   <= 1'b0;
      snooze_q     <= 1'b0;
      mode_q       <= MODE_RUN;
    end else begin
      state_q      <= state_d;
      btn_q        <= btn_now;
      edit_q       <= edit_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      bus_q        <= bus_d;
      tmo_q        <= tmo_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      stop_q       <= stop_d;
      alarm_on_q   <= alarm_on_d;
      snooze_q     <= snooze_d;
      mode_q       <= mode_d;
    end
  end

  assign hour_in1      = bus_q.h1;
  assign hour_in0      = bus_q.h0;
  assign minute_in1    = bus_q.m1;
  assign minute_in0    = bus_q.m0;
  assign load_time     = load_time_q;
  assign load_alarm    = load_alarm_q;
  assign stop_alarm    = stop_q;
  assign alarm_on      = alarm_on_q;
  assign mode          = mode_q;
  assign edit_digit    = digit_q;
  assign snooze_active = snooze_q;

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Bench for alarm_mode_controller: a UI-mode plus command-queue model checked every cycle,
// and directed scenarios with literal expectations for key bus and strobe values.
module tb_alarm_mode_controller;

  localparam int SNOOZE_MIN   = 5;
  localparam int EDIT_TIMEOUT = 30;
  localparam int B_UP = 0, B_NEXT = 1, B_MODE = 2, B_SNOOZE = 3;
  localparam int C_LT = 0, C_LA = 1, C_STOP = 2, C_SNZ = 3, C_RST = 4;
  localparam int UI_RUN = 0, UI_TIME = 1, UI_ALARM = 2;

  logic       clock = 1'b0;
  logic       reset, tick_1s, b_mode, b_up, b_next, b_snooze, alarm_active;
  logic [1:0] cur_hour1;
  logic [3:0] cur_hour0, cur_min1, cur_min0;
  logic [1:0] hour_in1, mode, edit_digit;
  logic [3:0] hour_in0, minute_in1, minute_in0;
  logic       load_time, load_alarm, stop_alarm, alarm_on, snooze_active;

  int checks = 0;
  int errors = 0;

  alarm_mode_controller #(.SNOOZE_MIN(SNOOZE_MIN), .EDIT_TIMEOUT(EDIT_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .tick_1s(tick_1s),
    .btn_mode(b_mode), .btn_up(b_up), .btn_next(b_next), .btn_snooze(b_snooze),
    .alarm_active(alarm_active),
    .cur_hour1(cur_hour1), .cur_hour0(cur_hour0), .cur_min1(cur_min1), .cur_min0(cur_min0),
    .hour_in1(hour_in1), .hour_in0(hour_in0), .minute_in1(minute_in1), .minute_in0(minute_in0),
    .load_time(load_time), .load_alarm(load_alarm), .stop_alarm(stop_alarm), .alarm_on(alarm_on),
    .mode(mode), .edit_digit(edit_digit), .snooze_active(snooze_active)
  );

  always #5 clock = ~clock;

  // ---------------- model ----------------
  bit       model_ok = 1'b0;
  int       m_ui, m_dig, m_tmo, tm, pick;
  int       m_edit[4], m_shadow[4], m_bus[4];
  bit       m_aon, m_snz, any_e, entered;
  bit [3:0] m_prev, now_b, e;
  int       q[$];

  always @(posedge clock) begin
    if (reset) begin
      model_ok = 1'b1;
      m_ui = UI_RUN; m_dig = 0; m_tmo = 0; m_aon = 0; m_snz = 0; m_prev = 4'hF;
      m_edit = '{0, 0, 0, 0}; m_shadow = '{0, 0, 0, 0}; m_bus = '{0, 0, 0, 0};
      q.delete();
    end else if (model_ok) begin
      now_b = {b_snooze, b_mode, b_next, b_up};
      e = now_b & ~m_prev;
      m_prev = now_b;
      any_e = |e;
      pick = e[3] ? B_SNOOZE : e[2] ? B_MODE : e[1] ? B_NEXT : e[0] ? B_UP : -1;
      entered = 0;
      if (q.size() != 0) begin
        if (tick_1s) begin
          if (q[0] == C_SNZ) m_snz = 1;
          if (q[0] == C_RST) m_snz = 0;
          void'(q.pop_front());
          entered = (q.size() != 0);
        end
      end else if (m_ui == UI_RUN) begin
        if (alarm_active) begin
          if (pick == B_SNOOZE) begin
            q.push_back(C_STOP); q.push_back(C_SNZ); entered = 1;
          end else if (pick == B_MODE) begin
            q.push_back(C_STOP); if (m_snz) q.push_back(C_RST); entered = 1;
          end
        end else if (pick == B_MODE) begin
          m_ui = UI_TIME; m_dig = 0; m_tmo = 0;
          m_edit = '{int'(cur_hour1), int'(cur_hour0), int'(cur_min1), int'(cur_min0)};
        end else if (pick == B_UP) begin
          m_aon = !m_aon;
        end
      end else begin
        if (any_e) m_tmo = 0;
        if (pick == B_MODE) begin
          if (m_ui == UI_TIME) begin m_ui = UI_ALARM; m_edit = m_shadow; m_dig = 0; end
          else m_ui = UI_RUN;
        end else if (pick == B_NEXT) begin
          if (m_dig == 3) begin
            if (m_ui == UI_TIME) q.push_back(C_LT);
            else begin q.push_back(C_LA); m_shadow = m_edit; end
            m_ui = UI_RUN; entered = 1;
          end else m_dig++;
        end else if (pick == B_UP) begin
          case (m_dig)
            0: begin
              m_edit[0] = (m_edit[0] + 1) % 3;
              if (m_edit[0] == 2 && m_edit[1] > 3) m_edit[1] = 3;
            end
            1: m_edit[1] = (m_edit[1] + 1) % ((m_edit[0] == 2) ? 4 : 10);
            2: m_edit[2] = (m_edit[2] + 1) % 6;
            default: m_edit[3] = (m_edit[3] + 1) % 10;
          endcase
        end else if (!any_e && tick_1s) begin
          m_tmo++;
          if (m_tmo >= EDIT_TIMEOUT) m_ui = UI_RUN;
        end
      end
      if (entered) begin
        case (q[0])
          C_LT, C_LA: m_bus = m_edit;
          C_SNZ: begin
            tm = ((int'(cur_hour1) * 10 + int'(cur_hour0)) * 60 + int'(cur_min1) * 10
                  + int'(cur_min0) + SNOOZE_MIN) % 1440;
            m_bus = '{tm / 600, (tm / 60) % 10, (tm % 60) / 10, tm % 10};
          end
          C_RST: m_bus = m_shadow;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [22:0] model_vec();
    logic lt, la, st;
    logic [1:0] md;
    lt = (q.size() != 0) && (q[0] == C_LT);
    la = (q.size() != 0) && (q[0] == C_LA || q[0] == C_SNZ || q[0] == C_RST);
    st = (q.size() != 0) && (q[0] == C_STOP);
    md = (q.size() != 0) ? 2'd0 : 2'(m_ui);
    return {2'(m_bus[0]), 4'(m_bus[1]), 4'(m_bus[2]), 4'(m_bus[3]),
            lt, la, st, m_aon, md, 2'(m_dig), m_snz};
  endfunction

  logic [22:0] dut_vec;
  assign dut_vec = {hour_in1, hour_in0, minute_in1, minute_in0, load_time, load_alarm,
                    stop_alarm, alarm_on, mode, edit_digit, snooze_active};

  always @(negedge clock) begin
    if (model_ok) begin
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL model_cycle t=%0t dut=%h expected=%h", $time, dut_vec, model_vec());
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int bus_now();
    return int'({hour_in1, hour_in0, minute_in1, minute_in0});
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP:    b_up = v;
      B_NEXT:  b_next = v;
      B_MODE:  b_mode = v;
      default: b_snooze = v;
    endcase
  endtask

  task automatic press(input int b, input int n = 1);
    repeat (n) begin
      set_btn(b, 1'b1); cyc(1);
      set_btn(b, 1'b0); cyc(1);
    end
  endtask

  task automatic tick();
    tick_1s = 1'b1; cyc(1);
    tick_1s = 1'b0; cyc(1);
  endtask

  task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
    cur_hour1 = 2'(h1); cur_hour0 = 4'(h0); cur_min1 = 4'(m1); cur_min0 = 4'(m0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; tick_1s = 0; b_mode = 0; b_up = 0; b_next = 0; b_snooze = 0; alarm_active = 0;
    set_cur(0, 0, 0, 0);
    cyc(3);
    chk("reset_outputs", int'(dut_vec), 0);
    reset = 0;
    cyc(1);

    press(B_UP);
    chk("run_up_toggles_alarm_on", int'(alarm_on), 1);
    press(B_NEXT);

    set_cur(0, 2, 0, 0);
    press(B_MODE);
    chk("edit_time_mode", int'(mode), 1);
    press(B_UP, 2); press(B_NEXT);
    press(B_UP, 5); press(B_NEXT);
    press(B_UP, 3); press(B_NEXT);
    press(B_NEXT);
    chk("commit_time_bus", bus_now(), 14'h2330);
    chk("commit_time_load", int'(load_time), 1);
    cyc(3);
    chk("commit_time_held", int'(load_time), 1);
    tick();
    chk("commit_time_drop", int'(load_time), 0);
    chk("mode_after_commit", int'(mode), 0);

    set_cur(1, 9, 0, 0);
    press(B_MODE); press(B_UP); press(B_NEXT, 4);
    chk("hour0_clamp_bus", bus_now(), 14'h2300);
    tick();
    press(B_MODE); press(B_UP, 2); press(B_NEXT, 4);
    chk("hour1_wrap_bus", bus_now(), 14'h0300);
    tick();

    press(B_MODE); press(B_MODE);
    chk("edit_alarm_mode", int'(mode), 2);
    press(B_NEXT); press(B_UP, 7); press(B_NEXT, 3);
    chk("commit_alarm_bus", bus_now(), 14'h0700);
    chk("commit_alarm_load", int'(load_alarm), 1);
    tick();

    press(B_MODE); press(B_MODE); press(B_UP);
    repeat (EDIT_TIMEOUT - 1) tick();
    chk("timeout_not_yet", int'(mode), 2);
    tick();
    chk("timeout_mode_run", int'(mode), 0);
    chk("timeout_no_load", int'(load_alarm), 0);

    set_cur(2, 3, 5, 7);
    alarm_active = 1;
    press(B_SNOOZE);
    chk("snooze_stop", int'(stop_alarm), 1);
    cyc(4);
    chk("snooze_stop_held", int'(stop_alarm), 1);
    tick();
    chk("snooze_stop_drop", int'(stop_alarm), 0);
    chk("snooze_load", int'(load_alarm), 1);
    chk("snooze_bus", bus_now(), 14'h0002);
    tick();
    chk("snooze_active_set", int'(snooze_active), 1);
    chk("snooze_load_drop", int'(load_alarm), 0);

    press(B_MODE);
    chk("dismiss_stop", int'(stop_alarm), 1);
    tick();
    chk("restore_load", int'(load_alarm), 1);
    chk("restore_bus", bus_now(), 14'h0700);
    tick();
    chk("snooze_active_clear", int'(snooze_active), 0);

    b_snooze = 1; b_mode = 1; cyc(1);
    b_snooze = 0; b_mode = 0; cyc(1);
    tick();
    chk("priority_snooze_path", int'(load_alarm), 1);
    alarm_active = 0;
    b_up = 1;
    reset = 1; cyc(1);
    chk("reset_mid_load", int'(dut_vec), 0);
    cyc(1);
    reset = 0; cyc(2);
    chk("held_button_no_edge", int'(alarm_on), 0);
    b_up = 0; cyc(1);
    press(B_UP);
    chk("up_after_reset", int'(alarm_on), 1);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
